cpu_player: RTL and testbench

Computer opponent for the tug-of-war game. Generates human-like button presses for the computer side from a 10-bit LFSR, compared each decision slot against a difficulty level from the switches. Sits directly upstream of the player-2 two-flop synchroniser and `userInput` edge detector, replacing a physical key. Every press is a clean high pulse followed by a guaranteed low gap, so the downstream edge detector counts exactly one move per press.

---
 rtl/cpu_player.sv | 110 +++++++++++
 tb/tb_cpu_player.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/cpu_player.sv
// Computer opponent: LFSR-driven key presses with fixed hold and cooldown.
// Define CPU_PRESS_CNT_EN to build the saturating press_count register.
module cpu_player #(
  parameter int HOLD_CYCLES = 2,
  parameter int COOLDOWN    = 4,
  parameter int CNT_W       = 8
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             enable,
  input  logic [8:0]       difficulty,
  output logic             press,
  output logic [9:0]       rand_q,
  output logic [CNT_W-1:0] press_count
);

  localparam int MAXC =
    (HOLD_CYCLES > COOLDOWN) ? HOLD_CYCLES : COOLDOWN;
  localparam int CW = (MAXC > 1) ? $clog2(MAXC) : 1;
  localparam logic [CW-1:0] HOLD_LD = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] COOL_LD = CW'(COOLDOWN - 1);

  typedef enum logic [1:0] {
    IDLE,
    PRESS,
    GAP
  } state_t;

  state_t        state;
  state_t        state_n;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_n;
  logic [9:0]    q;
  logic          hit;
  logic          start;

  assign hit    = ({1'b0, difficulty} > q);
  assign rand_q = q;

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    start   = 1'b0;
    if (!enable) begin
      state_n = IDLE;
      cnt_n   = '0;
    end else begin
      case (state)
        IDLE: begin
          if (hit) begin
            state_n = PRESS;
            cnt_n   = HOLD_LD;
            start   = 1'b1;
          end
        end
        PRESS: begin
          if (cnt == '0) begin
            state_n = GAP;
            cnt_n   = COOL_LD;
          end else begin
            cnt_n = cnt - 1'b1;
          end
        end
        GAP: begin
          if (cnt == '0) begin
            state_n = IDLE;
          end else begin
            cnt_n = cnt - 1'b1;
          end
        end
        default: begin
          state_n = IDLE;
          cnt_n   = '0;
        end
      endcase
    end
  end

  // XNOR LFSR free-runs so randomness keeps evolving between rounds
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      q     <= '0;
      state <= IDLE;
      cnt   <= '0;
      press <= 1'b0;
    end else begin
      q     <= {q[8:0], ~(q[9] ^ q[6])};
      state <= state_n;
      cnt   <= cnt_n;
      press <= (state_n == PRESS);
    end
  end

`ifdef CPU_PRESS_CNT_EN
  logic [CNT_W-1:0] pc;

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      pc <= '0;
    end else if (start && (pc != '1)) begin
      pc <= pc + 1'b1;
    end
  end

  assign press_count = pc;
`else
  assign press_count = '0;
`endif

endmodule

// File: tb/tb_cpu_player.sv
// Scoreboard bench for cpu_player against a timeline model of presses.
// Model tracks press windows and the next allowed decision cycle.
module tb_cpu_player;

  localparam int H = 2;
  localparam int C = 4;
  localparam int W = 3;
  localparam int SAT = (1 << W) - 1;

  logic         Clock = 1'b0;
  logic         Reset = 1'b0;
  logic         enable = 1'b0;
  logic [8:0]   difficulty = '0;
  logic         press;
  logic [9:0]   rand_q;
  logic [W-1:0] press_count;

  cpu_player #(
    .HOLD_CYCLES(H),
    .COOLDOWN(C),
    .CNT_W(W)
  ) dut (
    .Clock(Clock),
    .Reset(Reset),
    .enable(enable),
    .difficulty(difficulty),
    .press(press),
    .rand_q(rand_q),
    .press_count(press_count)
  );

  always #5 Clock = ~Clock;

  typedef struct packed {
    logic         p;
    logic [9:0]   q;
    logic [W-1:0] c;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int checks = 0;
  int errors = 0;

  int cyc;
  int free_at;
  int press_lo;
  int press_hi;
  int presses;
  logic [9:0] mq;
  logic last_p;

  function automatic logic [9:0] lfsr_next(input logic [9:0] v);
    return {v[8:0], ~(v[9] ^ v[6])};
  endfunction

  function automatic int exp_cnt();
`ifdef CPU_PRESS_CNT_EN
    return (presses > SAT) ? SAT : presses;
`else
    return 0;
`endif
  endfunction

  task automatic chk(input string name,
                     input logic [31:0] got,
                     input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %0h exp %0h at %0t",
               name, got, want, $time);
    end
  endtask

  task automatic model_reset();
    cyc      = 0;
    free_at  = 0;
    press_lo = 0;
    press_hi = -1;
    presses  = 0;
    mq       = '0;
  endtask

  // called at a negedge; drives inputs, predicts next edge, waits
  task automatic step(input logic en, input logic [8:0] d);
    enable     = en;
    difficulty = d;
    if (!en) begin
      free_at  = cyc + 1;
      press_hi = -1;
    end else if (cyc >= free_at && int'(d) > int'(mq)) begin
      press_lo = cyc;
      press_hi = cyc + H - 1;
      free_at  = cyc + H + C + 1;
      presses++;
    end
    last_p = (cyc >= press_lo && cyc <= press_hi);
    mq = lfsr_next(mq);
    sb.push_back({last_p, mq, W'(exp_cnt())});
    cyc++;
    @(negedge Clock);
  endtask

  task automatic do_reset();
    Reset = 1'b0;
    #1;
    chk("rst_press", press, 0);
    chk("rst_rand_q", rand_q, 0);
    chk("rst_count", press_count, 0);
    model_reset();
    @(negedge Clock);
    Reset = 1'b1;
  endtask

  always @(posedge Clock) begin
    #1;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("press", press, e.p);
      chk("rand_q", rand_q, e.q);
      chk("count", press_count, e.c);
    end
  end

  initial begin
    logic [8:0] d;
    int r;
    int n;
    model_reset();
    #1;
    chk("init_press", press, 0);
    chk("init_rand_q", rand_q, 0);
    chk("init_count", press_count, 0);
    @(negedge Clock);
    Reset = 1'b1;

    repeat (2100) step(1'b1, 9'd0);

    do_reset();
    repeat (200) step(1'b1, 9'd1);

    do_reset();
    repeat (1023) step(1'b1, 9'd511);

    n = 0;
    do begin
      step(1'b1, 9'd511);
      n++;
    end while (!last_p && n < 40);
    chk("drop_found", last_p, 1);
    step(1'b1, 9'd511);
    repeat (6) step(1'b0, 9'd511);

    repeat (3000) begin
      r = $urandom_range(0, 3);
      if (r == 0) d = 9'd511;
      else if (r == 1) d = mq[9] ? 9'd0 : mq[8:0];
      else d = 9'($urandom_range(0, 511));
      step($urandom_range(0, 9) != 0, d);
    end

    n = 0;
    do begin
      step(1'b1, 9'd511);
      n++;
    end while (!last_p && n < 40);
    chk("pre_rst_press", press, last_p);
    do_reset();
    repeat (50) step(1'b1, 9'd300);

    n = 0;
    while (sb.size() > 0 && n < 10) begin
      @(negedge Clock);
      n++;
    end
    chk("sb_drained", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
